minmax_scan_ctrl: RTL
=====================

// Module: minmax_scan_ctrl
// PURPOSE
//  Sequencer that scans a burst of 4-bit samples and reports the max and min values and their indices.
//  Only one 4-bit magnitude comparator cell (equal/greater/lesser outputs) is instantiated.
//  That single comparator is time-shared between the max update and the min update.
//  Sits between a sample producer (valid/ready) and downstream status/threshold logic.
// PARAMETERS
//  CNT_W  4  width of len, internal sample counter and index outputs; max burst = 2**CNT_W-1
// PORTS
//  clk      in   1      clock, all logic on rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      begin a scan; sampled only in IDLE
//  len      in   CNT_W  number of samples in burst, latched on accepted start
//  in_valid in   1      sample valid
//  in_data  in   4      sample value, unsigned
//  in_ready out  1      block can accept a sample this cycle
//  busy     out  1      high in every state except IDLE
//  done     out  1      one-cycle pulse: results valid and final
//  max_val  out  4      largest sample of last completed/ongoing scan
//  max_idx  out  CNT_W  index (0-based) of first occurrence of max
//  min_val  out  4      smallest sample
//  min_idx  out  CNT_W  index of first occurrence of min
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and internal registers 0 (in_ready=0, busy=0, done=0).
//  States: IDLE, FIRST, WAIT, CMP_MAX, CMP_MIN, DONE.
//  IDLE: start=1 & len!=0 -> latch len, cnt=0, go FIRST. start with len==0: ignored, no done.
//   Results keep last values until the FIRST sample of the next scan is accepted.
//  FIRST: in_ready=1. On in_valid: max=min=in_data, max_idx=min_idx=0, cnt=1.
//   Next state is DONE if len==1, else WAIT.
//  WAIT: in_ready=1. On in_valid: smp<=in_data, sidx<=cnt, cnt<=cnt+1, go CMP_MAX.
//   Otherwise stay in WAIT. No timeout.
//  CMP_MAX: comparator a=smp, b=max_val. If greater: max_val<=smp, max_idx<=sidx. Go CMP_MIN.
//  CMP_MIN: comparator a=smp, b=min_val. If lesser: min_val<=smp, min_idx<=sidx.
//   Next state is DONE if cnt==len, else WAIT.
//  DONE: done=1 for exactly this cycle; next state IDLE.
//  in_ready=1 only in FIRST and WAIT; a sample is accepted only on in_valid & in_ready.
//  Ties (equal): no update, so the earliest index wins for both max and min.
//  Throughput: 1 cycle for the first sample, then 3 cycles per sample.
//   Latency from last sample accepted to done = 3 cycles (1 cycle if len==1).
//  start while busy: ignored, with no effect on len or cnt.
//  Comparator b-input mux: max_val in CMP_MAX, min_val otherwise. Compare is unsigned.
//  cnt never wraps: cnt <= len <= 2**CNT_W-1.
//  rst mid-scan: immediate return to IDLE with all outputs 0. No done pulse.
// TESTING
//  1 len=4, samples 3,9,1,7 -> done once.
//    Required: max=9 idx1, min=1 idx2; done 3 cycles after 4th accept.
//  2 len=1, sample 5 -> max=min=5, idx 0.
//    Required: done 1 cycle after accept, in_ready=0 in DONE.
//  3 len=5, samples 6,6,2,F,2 -> max=F idx3, min=2 idx2 (first occurrence kept).
//  4 len=3 with in_valid gaps of 0..4 cycles and start pulses while busy.
//    Required: identical results to the gap-free run; len not relatched.
//  5 start with len=0 -> stays IDLE, busy=0, no done. Then len=2, samples 0,F.
//    Required: min=0 idx0, max=F idx1.
//  6 rst asserted after 2nd sample of len=4.
//    Required: next cycle all outputs 0, IDLE. A fresh scan completes correctly.

Source files
------------

// File: rtl/minmax_scan_ctrl.sv
// Burst min/max scanner: walks a valid/ready sample stream and tracks the extreme
// values and their first-occurrence indices using one shared magnitude comparator.

module mag_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);
  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);
endmodule

// state   | meaning
// IDLE    | waiting for start with a non-zero len
// FIRST   | accept sample 0, seeds max/min directly
// WAIT    | accept next sample into smp/sidx
// CMP_MAX | comparator b = max_val, update max on greater
// CMP_MIN | comparator b = min_val, update min on lesser
// DONE    | one-cycle done pulse, results final
module minmax_scan_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [3:0]       max_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [3:0]       min_val,
  output logic [CNT_W-1:0] min_idx
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRST   = 3'd1,
    WAIT    = 3'd2,
    CMP_MAX = 3'd3,
    CMP_MIN = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sidx;
  logic [3:0]       smp;
  logic [3:0]       cmp_b;
  logic             cmp_eq, cmp_gt, cmp_lt;
  logic             upd_max, upd_min;

  assign cmp_b = (state == CMP_MAX) ? max_val : min_val;

  mag_cmp4 u_cmp (
    .a  (smp),
    .b  (cmp_b),
    .eq (cmp_eq),
    .gt (cmp_gt),
    .lt (cmp_lt)
  );

  // ties never update, so the earliest index is kept for both extremes
  assign upd_max = (state == CMP_MAX) && cmp_gt && !cmp_eq;
  assign upd_min = (state == CMP_MIN) && cmp_lt && !cmp_eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && (len != '0)) state_nxt = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (len_q == CNT_W'(1)) ? DONE : WAIT;
      end
      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CMP_MAX;
      end
      CMP_MAX: state_nxt = CMP_MIN;
      CMP_MIN: state_nxt = (cnt == len_q) ? DONE : WAIT;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt     <= '0;
      sidx    <= '0;
      smp     <= '0;
      max_val <= '0;
      max_idx <= '0;
      min_val <= '0;
      min_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q <= len;
            cnt   <= '0;
          end
        end
        FIRST: begin
          if (in_valid) begin
            max_val <= in_data;
            min_val <= in_data;
            max_idx <= '0;
            min_idx <= '0;
            cnt     <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (in_valid) begin
            smp  <= in_data;
            sidx <= cnt;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (upd_max) begin
        max_val <= smp;
        max_idx <= sidx;
      end
      if (upd_min) begin
        min_val <= smp;
        min_idx <= sidx;
      end
    end
  end

endmodule
